fetch_hazard_ctrl: RTL and testbench
====================================

FETCH_HAZARD_CTRL -- requirements
Module: fetch_hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port Z  input  1  branch taken, ID stage.
REQ-004 SHALL have port J  input  1  jump, ID stage.
REQ-005 SHALL have port JR  input  1  jump-register, ID stage.
REQ-006 SHALL have port MemRead_ex  input  1  EX-stage instruction is a load.
REQ-007 SHALL have port RegisterRt_ex  input  5  load destination, EX stage.
REQ-008 SHALL have ports RegisterRs_id and RegisterRt_id  input  5 each  source registers, ID stage.
REQ-009 SHALL have port imem_ready  input  1  instruction memory returns valid word this cycle.
REQ-010 SHALL have port PC_IFWrite  output  1  PC update enable to IF.
REQ-011 SHALL have port IFID_Write  output  1  IF/ID register load enable.
REQ-012 SHALL have port IFID_flush  output  1  zero IF/ID contents (squash fetched word).
REQ-013 SHALL have port ID_bubble  output  1  zero ID/EX control signals.
REQ-014 SHALL have port PCSrc  output  2  00 sequential, 01 branch, 10 jump, 11 jr.
REQ-015 SHALL have ports stall_cnt and redirect_cnt  output  16 each  saturating performance counters.

Function
REQ-016 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, REDIR_PEND; state register clocked by clk.
REQ-017 SHALL detect load-use as MemRead_ex & (RegisterRt_ex != 0) & (RegisterRt_ex == RegisterRs_id | RegisterRt_ex == RegisterRt_id).
REQ-018 SHALL prioritise per cycle: reset > load-use > redirect > memory wait > normal advance.
REQ-019 SHALL select redirect as JR > J > Z; PCSrc encodes the winner, 00 when none.
REQ-020 RUN, no event, imem_ready=1: PC_IFWrite=1, IFID_Write=1, IFID_flush=0, ID_bubble=0, PCSrc=00.
REQ-021 Load-use in RUN: PC_IFWrite=0, IFID_Write=0, ID_bubble=1, PCSrc=00, Z/J/JR ignored that cycle; next state LU_STALL.
REQ-022 LU_STALL SHALL last exactly one cycle with outputs as RUN normal advance, then RUN; a second load-use hit in LU_STALL SHALL re-stall.
REQ-023 Redirect in RUN with imem_ready=1: PC_IFWrite=1, IFID_flush=1, PCSrc=winner, same cycle; stay RUN.
REQ-024 Redirect in RUN with imem_ready=0: latch winner into pend_sel, PC_IFWrite=0, IFID_Write=0; next state REDIR_PEND.
REQ-025 REDIR_PEND: hold outputs stalled until imem_ready=1, then PC_IFWrite=1, IFID_flush=1, PCSrc=pend_sel for one cycle, next RUN; new Z/J/JR ignored while pending.
REQ-026 No redirect, imem_ready=0 in RUN: PC_IFWrite=0, IFID_Write=0, IFID_flush=0; next MEM_WAIT; MEM_WAIT returns to RUN on the cycle imem_ready=1 with normal-advance outputs.
REQ-027 Redirect arriving in MEM_WAIT SHALL behave as REQ-024 (imem_ready=0) or REQ-023 (imem_ready=1).
REQ-028 stall_cnt SHALL increment each cycle PC_IFWrite=0; redirect_cnt each cycle IFID_flush=1; both saturate at 16'hFFFF.
REQ-029 Outputs SHALL be combinational from state, pend_sel and current inputs; no extra latency.

Reset
REQ-030 reset=1 at a rising edge SHALL set state=RUN, pend_sel=00, stall_cnt=0, redirect_cnt=0.
REQ-031 While reset=1: PC_IFWrite=0, IFID_Write=0, IFID_flush=1, ID_bubble=1, PCSrc=00.
REQ-032 Reset mid-stall or mid-pending SHALL discard pend_sel; no redirect applied after release.

Structure
REQ-033 State encoding and PCSrc constants (PC_SEQ, PC_BR, PC_J, PC_JR) SHALL live in shared pipeline package/header.
REQ-034 One sub-module sat_counter16 (enable, synchronous clear) SHALL be instantiated twice.
REQ-035 Hazard compare and FSM SHALL remain in fetch_hazard_ctrl; target 150-250 RTL lines.

Verification
REQ-036 reset 2 cycles, imem_ready=1, no events -> PC_IFWrite=1, PCSrc=00, stall_cnt=0 after 10 cycles.
REQ-037 MemRead_ex=1, Rt_ex=8, Rs_id=8 one cycle -> exactly one cycle PC_IFWrite=0, ID_bubble=1; stall_cnt=1; Rt_ex=0 -> no stall.
REQ-038 JR=1, J=1, Z=1 simultaneously, imem_ready=1 -> PCSrc=11, IFID_flush=1 one cycle, redirect_cnt=1.
REQ-039 Z=1 with imem_ready=0 for 3 cycles, Z dropped next cycle -> 3 stall cycles, then PCSrc=01, IFID_flush=1 on ready cycle.
REQ-040 Load-use and J=1 same cycle -> stall, PCSrc=00; J held next cycle -> PCSrc=10, IFID_flush=1.
REQ-041 reset asserted in REDIR_PEND, imem_ready=1 after release -> PCSrc=00, no flush, counters 0.

Source files
------------

// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the fetch hazard controller: FSM states,
// PC source select codes and the redirect priority helper.
package fetch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LU_STALL   = 2'b01,
        MEM_WAIT   = 2'b10,
        REDIR_PEND = 2'b11
    } fetch_state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    // Jump-register beats jump, jump beats a taken branch.
    function automatic logic [1:0] redirect_sel(input logic z, input logic j, input logic jr);
        logic [1:0] sel;
        if (jr) begin
            sel = PC_JR;
        end else if (j) begin
            sel = PC_J;
        end else if (z) begin
            sel = PC_BR;
        end else begin
            sel = PC_SEQ;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear (clear wins over enable).
module sat_counter16 (
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear first, otherwise step up until the counter pins at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 16'd0;
        end else if (enable && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard controller: load-use stalls, branch/jump redirects,
// instruction-memory wait handling and stall/redirect performance counters.
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        MemRead_ex,
    input  logic [4:0]  RegisterRt_ex,
    input  logic [4:0]  RegisterRs_id,
    input  logic [4:0]  RegisterRt_id,
    input  logic        imem_ready,
    output logic        PC_IFWrite,
    output logic        IFID_Write,
    output logic        IFID_flush,
    output logic        ID_bubble,
    output logic [1:0]  PCSrc,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [1:0]   pend_sel_q;
    logic [1:0]   pend_sel_d;
    logic         load_use;
    logic [1:0]   redir_sel;
    logic         redir_req;

    assign load_use  = MemRead_ex && (RegisterRt_ex != 5'd0) &&
                       ((RegisterRt_ex == RegisterRs_id) || (RegisterRt_ex == RegisterRt_id));
    assign redir_sel = redirect_sel(Z, J, JR);
    assign redir_req = (redir_sel != PC_SEQ);

    // Next state and outputs, in priority order reset > load-use > redirect > memory wait > advance.
    always_comb begin
        state_d    = RUN;
        pend_sel_d = pend_sel_q;
        PC_IFWrite = 1'b1;
        IFID_Write = 1'b1;
        IFID_flush = 1'b0;
        ID_bubble  = 1'b0;
        PCSrc      = PC_SEQ;
        if (reset) begin
            PC_IFWrite = 1'b0;
            IFID_Write = 1'b0;
            IFID_flush = 1'b1;
            ID_bubble  = 1'b1;
            pend_sel_d = PC_SEQ;
        end else if (load_use) begin
            PC_IFWrite = 1'b0;
            IFID_Write = 1'b0;
            ID_bubble  = 1'b1;
            state_d    = (state_q == REDIR_PEND) ? REDIR_PEND : LU_STALL;
        end else if (state_q == REDIR_PEND) begin
            if (imem_ready) begin
                IFID_flush = 1'b1;
                PCSrc      = pend_sel_q;
                pend_sel_d = PC_SEQ;
            end else begin
                PC_IFWrite = 1'b0;
                IFID_Write = 1'b0;
                state_d    = REDIR_PEND;
            end
        end else if (redir_req) begin
            if (imem_ready) begin
                IFID_flush = 1'b1;
                PCSrc      = redir_sel;
            end else begin
                PC_IFWrite = 1'b0;
                IFID_Write = 1'b0;
                pend_sel_d = redir_sel;
                state_d    = REDIR_PEND;
            end
        end else if (!imem_ready) begin
            PC_IFWrite = 1'b0;
            IFID_Write = 1'b0;
            state_d    = MEM_WAIT;
        end
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        pend_sel_q <= pend_sel_d;
    end

    sat_counter16 u_stall_cnt (
        .clk    (clk),
        .clear  (reset),
        .enable (~PC_IFWrite),
        .count  (stall_cnt)
    );

    sat_counter16 u_redirect_cnt (
        .clk    (clk),
        .clear  (reset),
        .enable (IFID_flush),
        .count  (redirect_cnt)
    );

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scenario bench for fetch_hazard_ctrl: each step drives one cycle of inputs,
// pushes its expected outputs, then pops and compares before the next edge.
module tb_fetch_hazard_ctrl;

    typedef struct {
        string      name;
        logic       rst;
        logic       z;
        logic       j;
        logic       jr;
        logic       mr;
        logic [4:0] rtex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ready;
        logic [5:0] val;
        logic [5:0] mask;
    } step_t;

    typedef struct {
        string      name;
        logic [5:0] val;
        logic [5:0] mask;
    } exp_t;

    // Output vector layout: {PC_IFWrite, IFID_Write, IFID_flush, ID_bubble, PCSrc}
    localparam logic [5:0] NORM  = 6'b110000;
    localparam logic [5:0] LU    = 6'b000100;
    localparam logic [5:0] STALL = 6'b000000;
    localparam logic [5:0] RST   = 6'b001100;
    localparam logic [5:0] ALL   = 6'b111111;
    localparam logic [5:0] NOBUB = 6'b111011;
    localparam logic [5:0] RDM   = 6'b101111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Z = 1'b0, J = 1'b0, JR = 1'b0, MemRead_ex = 1'b0;
    logic [4:0]  RegisterRt_ex = '0, RegisterRs_id = '0, RegisterRt_id = '0;
    logic        imem_ready = 1'b1;
    logic        PC_IFWrite, IFID_Write, IFID_flush, ID_bubble;
    logic [1:0]  PCSrc;
    logic [15:0] stall_cnt, redirect_cnt;
    logic [5:0]  obs;

    int   tests = 0;
    int   failed = 0;
    exp_t sb[$];

    assign obs = {PC_IFWrite, IFID_Write, IFID_flush, ID_bubble, PCSrc};

    always #5 clk = ~clk;

    fetch_hazard_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .Z             (Z),
        .J             (J),
        .JR            (JR),
        .MemRead_ex    (MemRead_ex),
        .RegisterRt_ex (RegisterRt_ex),
        .RegisterRs_id (RegisterRs_id),
        .RegisterRt_id (RegisterRt_id),
        .imem_ready    (imem_ready),
        .PC_IFWrite    (PC_IFWrite),
        .IFID_Write    (IFID_Write),
        .IFID_flush    (IFID_flush),
        .ID_bubble     (ID_bubble),
        .PCSrc         (PCSrc),
        .stall_cnt     (stall_cnt),
        .redirect_cnt  (redirect_cnt)
    );

    function automatic logic [5:0] redir(input logic [1:0] sel);
        return {4'b1010, sel};
    endfunction

    function automatic step_t mk(input string name, input logic rst, input logic z, input logic j,
                                 input logic jr, input logic mr, input logic [4:0] rtex,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic ready,
                                 input logic [5:0] val, input logic [5:0] mask);
        step_t s;
        s.name = name; s.rst = rst; s.z = z; s.j = j; s.jr = jr; s.mr = mr;
        s.rtex = rtex; s.rs = rs; s.rt = rt; s.ready = ready; s.val = val; s.mask = mask;
        return s;
    endfunction

    task automatic applyStimulus(input step_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; Z = s.z; J = s.j; JR = s.jr; MemRead_ex = s.mr;
        RegisterRt_ex = s.rtex; RegisterRs_id = s.rs; RegisterRt_id = s.rt; imem_ready = s.ready;
        e.name = s.name; e.val = s.val; e.mask = s.mask;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        for (int k = 0; k < 10; k++) st.push_back(mk("idle_adv", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL reset/%s step %0d: got %b want %b mask %b", e.name, i, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset stall_cnt: got %0d want 0", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset redirect_cnt: got %0d want 0", redirect_cnt); end
    endtask

    task automatic test_load_use();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("lu_rs", 0, 0, 0, 0, 1, 8, 8, 0, 1, LU, ALL));
        st.push_back(mk("lu_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        st.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        st.push_back(mk("rt_ex_zero", 0, 0, 0, 0, 1, 0, 0, 0, 1, NORM, ALL));
        st.push_back(mk("no_memread", 0, 0, 0, 0, 0, 8, 8, 0, 1, NORM, ALL));
        st.push_back(mk("lu_rt", 0, 0, 0, 0, 1, 8, 3, 8, 1, LU, ALL));
        st.push_back(mk("lu_again", 0, 0, 0, 0, 1, 8, 8, 3, 1, LU, ALL));
        st.push_back(mk("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL load_use/%s: got %b want %b mask %b", e.name, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd3) begin failed++; $display("[TB] FAIL load_use stall_cnt: got %0d want 3", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd0) begin failed++; $display("[TB] FAIL load_use redirect_cnt: got %0d want 0", redirect_cnt); end
    endtask

    task automatic test_redirect_priority();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("jr_j_z", 0, 1, 1, 1, 0, 0, 0, 0, 1, redir(2'b11), RDM));
        st.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        st.push_back(mk("j_z", 0, 1, 1, 0, 0, 0, 0, 0, 1, redir(2'b10), RDM));
        st.push_back(mk("z", 0, 1, 0, 0, 0, 0, 0, 0, 1, redir(2'b01), RDM));
        st.push_back(mk("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL priority/%s: got %b want %b mask %b", e.name, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd0) begin failed++; $display("[TB] FAIL priority stall_cnt: got %0d want 0", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd3) begin failed++; $display("[TB] FAIL priority redirect_cnt: got %0d want 3", redirect_cnt); end
    endtask

    task automatic test_redirect_pending();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("z_wait1", 0, 1, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("z_jr_wait2", 0, 1, 0, 1, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("z_wait3", 0, 1, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("ready_apply", 0, 0, 0, 0, 0, 0, 0, 0, 1, redir(2'b01), RDM));
        st.push_back(mk("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL pending/%s: got %b want %b mask %b", e.name, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd3) begin failed++; $display("[TB] FAIL pending stall_cnt: got %0d want 3", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd1) begin failed++; $display("[TB] FAIL pending redirect_cnt: got %0d want 1", redirect_cnt); end
    endtask

    task automatic test_mem_wait();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("wait1", 0, 0, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("wait2", 0, 0, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        st.push_back(mk("wait3", 0, 0, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("j_ready_in_wait", 0, 0, 1, 0, 0, 0, 0, 0, 1, redir(2'b10), RDM));
        st.push_back(mk("wait4", 0, 0, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("jr_notready_in_wait", 0, 0, 0, 1, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("jr_apply", 0, 0, 0, 0, 0, 0, 0, 0, 1, redir(2'b11), RDM));
        st.push_back(mk("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL mem_wait/%s: got %b want %b mask %b", e.name, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd5) begin failed++; $display("[TB] FAIL mem_wait stall_cnt: got %0d want 5", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd2) begin failed++; $display("[TB] FAIL mem_wait redirect_cnt: got %0d want 2", redirect_cnt); end
    endtask

    task automatic test_load_use_vs_jump();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("lu_and_j", 0, 0, 1, 0, 1, 5, 0, 5, 1, LU, ALL));
        st.push_back(mk("j_held", 0, 0, 1, 0, 0, 0, 0, 0, 1, redir(2'b10), RDM));
        st.push_back(mk("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL lu_vs_j/%s: got %b want %b mask %b", e.name, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd1) begin failed++; $display("[TB] FAIL lu_vs_j stall_cnt: got %0d want 1", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd1) begin failed++; $display("[TB] FAIL lu_vs_j redirect_cnt: got %0d want 1", redirect_cnt); end
    endtask

    task automatic test_reset_pending();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("z_pend", 0, 1, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("z_pend2", 0, 1, 0, 0, 0, 0, 0, 0, 0, STALL, NOBUB));
        st.push_back(mk("rst_in_pend", 1, 0, 0, 0, 0, 0, 0, 0, 0, RST, ALL));
        st.push_back(mk("rst_ready", 1, 0, 0, 0, 0, 0, 0, 0, 1, RST, ALL));
        st.push_back(mk("after_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        st.push_back(mk("after_release2", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, ALL));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            #2;
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                failed++;
                $display("[TB] FAIL reset_pend/%s: got %b want %b mask %b", e.name, obs, e.val, e.mask);
            end
        end
        @(negedge clk); #2;
        tests++;
        if (stall_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset_pend stall_cnt: got %0d want 0", stall_cnt); end
        tests++;
        if (redirect_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset_pend redirect_cnt: got %0d want 0", redirect_cnt); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_redirect_pending();
        test_mem_wait();
        test_load_use_vs_jump();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
